// File: rtl/prod_accum_pkg.sv
// Shared types and default sizing for the product accumulator.
// Imported by the accumulator top and its edge-detector sub-module.
package prod_accum_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_GUARD   = 8;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for the multiplier done level.
// The first clock after reset only loads the history, so a level already high is not an edge.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_q;
  logic r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q     <= d;
      r_armed <= 1'b1;
    end
  end

  assign rise = d & ~r_q & r_armed;

endmodule

// File: rtl/prod_accum.sv
// Accumulates a run of signed multiplier products, one per done edge, and holds the
// finished sum until the consumer accepts it.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int PW      = 2 * N,
  parameter int GUARD   = DEF_GUARD,
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int ACC_W  = PW + GUARD,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LW-1:0]           len,
  input  logic signed [PW-1:0]    product,
  input  logic                    done,
  output logic                    busy,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    drop
);

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_L     = LW'(1);

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [LW-1:0]           r_remaining;
  logic                    r_busy;
  logic                    r_out_valid;
  logic                    r_drop;

  logic                    w_rise;
  logic [LW-1:0]           w_len_clamped;
  logic signed [ACC_W-1:0] w_product_ext;

  rise_det u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .d    (done),
    .rise (w_rise)
  );

  assign w_len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign w_product_ext = {{GUARD{product[PW-1]}}, product};

  // Guard bits make the sum overflow-free for MAX_LEN terms, so no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_drop <= 1'b0;
            if (w_len_clamped == '0) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_remaining <= w_len_clamped;
              r_state     <= ACCUM;
              r_busy      <= 1'b1;
            end
          end else if (w_rise) begin
            r_drop <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_rise) begin
            r_acc       <= r_acc + w_product_ext;
            r_remaining <= r_remaining - ONE_L;
            if (r_remaining == ONE_L) begin
              r_state     <= HOLD;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_rise) begin
            r_drop <= 1'b1;
          end
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign drop      = r_drop;

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum: a table of complete runs plus
// hand-written sequences for held done, empty runs, clamping, drops and resets.
module tb_prod_accum;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [8:0]          len;
  logic signed [63:0]  product;
  logic                done;
  logic                busy;
  logic signed [71:0]  acc_out;
  logic                out_valid;
  logic                out_ready;
  logic                drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               len;
    int               n;
    logic [3:0][63:0] prods;
    logic [71:0]      exp;
  } vec_t;

  vec_t vecs [6];

  prod_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .product   (product),
    .done      (done),
    .busy      (busy),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [63:0] p);
    product = p;
    done    = 1'b1;
    tick();
    done    = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int k = 0;
    while (!out_valid && k < max_cycles) begin
      tick();
      k++;
    end
    check({name, "_valid"}, {71'd0, out_valid}, 72'd1);
  endtask

  task automatic handshake(input string name, input logic [71:0] exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_clr"}, {71'd0, out_valid}, 72'd0);
    check({name, "_retain"}, acc_out, exp);
  endtask

  task automatic do_run(input string name, input int l, input logic [3:0][63:0] p,
                        input int n, input logic [71:0] exp);
    start = 1'b1;
    len   = 9'(l);
    tick();
    start = 1'b0;
    if (l > 0) check({name, "_busy"}, {71'd0, busy}, 72'd1);
    for (int i = 0; i < n; i++) pulse(p[i]);
    wait_valid(name, 8);
    check({name, "_acc"}, acc_out, exp);
    check({name, "_drop"}, {71'd0, drop}, 72'd0);
    check({name, "_busy_clr"}, {71'd0, busy}, 72'd0);
    handshake(name, exp);
    $display("run %s len=%0d acc_out=0x%0h", name, l, acc_out);
  endtask

  initial begin
    vecs[0] = '{len: 3, n: 3, exp: 72'd98,
                prods: {64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd5}};
    vecs[1] = '{len: 2, n: 2, exp: 72'hFF_FFFF_FFFF_FFFF_FFFE,
                prods: {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}};
    vecs[2] = '{len: 4, n: 4, exp: 72'd10,
                prods: {64'd4, 64'd3, 64'd2, 64'd1}};
    vecs[3] = '{len: 2, n: 2, exp: 72'h00_8000_0000_0000_0000,
                prods: {64'd0, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000}};
    vecs[4] = '{len: 0, n: 0, exp: 72'd0,
                prods: {64'd0, 64'd0, 64'd0, 64'd0}};
    vecs[5] = '{len: 1, n: 1, exp: 72'hFF_8000_0000_0000_0000,
                prods: {64'd0, 64'd0, 64'd0, 64'h8000_0000_0000_0000}};

    rst = 1'b1; start = 1'b0; len = '0; product = '0; done = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_busy", {71'd0, busy}, 72'd0);
    check("rst_valid", {71'd0, out_valid}, 72'd0);
    check("rst_drop", {71'd0, drop}, 72'd0);
    check("rst_acc", acc_out, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table of complete runs
    for (int v = 0; v < 6; v++)
      do_run($sformatf("vec%0d", v), vecs[v].len, vecs[v].prods, vecs[v].n, vecs[v].exp);

    // done held high for 20 cycles counts as one product
    start = 1'b1; len = 9'd1; tick(); start = 1'b0;
    product = 64'h3FFF_FFFF_0000_0001;
    done = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    done = 1'b0;
    tick();
    check("held_valid", {71'd0, out_valid}, 72'd1);
    check("held_acc", acc_out, 72'h00_3FFF_FFFF_0000_0001);
    check("held_drop", {71'd0, drop}, 72'd0);
    handshake("held", 72'h00_3FFF_FFFF_0000_0001);
    $display("run held len=1 acc_out=0x%0h", acc_out);

    // Empty run stays in HOLD; start on the accepting cycle is ignored
    start = 1'b1; len = 9'd0; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), {71'd0, out_valid}, 72'd1);
      check($sformatf("hold%0d_acc", i), acc_out, 72'd0);
      tick();
    end
    start = 1'b1; len = 9'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("hold_exit_valid", {71'd0, out_valid}, 72'd0);
    tick();
    check("hold_start_ignored", {71'd0, busy}, 72'd0);
    $display("run empty_hold len=0 acc_out=0x%0h", acc_out);

    // 256 terms of -(2^62) reach -(2^70) without wrapping
    start = 1'b1; len = 9'd256; tick(); start = 1'b0;
    for (int i = 0; i < 256; i++) pulse(64'hC000_0000_0000_0000);
    wait_valid("max", 8);
    check("max_acc", acc_out, 72'hC0_0000_0000_0000_0000);
    handshake("max", 72'hC0_0000_0000_0000_0000);
    $display("run max len=256 acc_out=0x%0h", acc_out);

    // len above MAX_LEN is clamped to 256 terms
    start = 1'b1; len = 9'd300; tick(); start = 1'b0;
    for (int i = 0; i < 255; i++) pulse(64'd1);
    check("clamp_busy255", {71'd0, busy}, 72'd1);
    check("clamp_valid255", {71'd0, out_valid}, 72'd0);
    pulse(64'd1);
    wait_valid("clamp", 8);
    check("clamp_acc", acc_out, 72'd256);
    handshake("clamp", 72'd256);
    $display("run clamp len=300 acc_out=0x%0h", acc_out);

    // Done edges in IDLE and HOLD are dropped and flagged
    pulse(64'd42);
    check("idle_drop_acc", acc_out, 72'd256);
    check("idle_drop_flag", {71'd0, drop}, 72'd1);
    start = 1'b1; len = 9'd1; tick(); start = 1'b0;
    check("start_clears_drop", {71'd0, drop}, 72'd0);
    pulse(64'd3);
    wait_valid("hold_drop", 8);
    pulse(64'd9);
    check("hold_drop_flag", {71'd0, drop}, 72'd1);
    check("hold_drop_acc", acc_out, 72'd3);
    check("hold_drop_valid", {71'd0, out_valid}, 72'd1);
    handshake("hold_drop", 72'd3);
    check("drop_sticky", {71'd0, drop}, 72'd1);
    $display("run drops acc_out=0x%0h drop=%0d", acc_out, drop);

    // Reset mid-run abandons it; a fresh run then completes normally
    start = 1'b1; len = 9'd4; tick(); start = 1'b0;
    pulse(64'd1);
    pulse(64'd1);
    check("mid_acc", acc_out, 72'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {71'd0, busy}, 72'd0);
    check("mid_rst_valid", {71'd0, out_valid}, 72'd0);
    check("mid_rst_acc", acc_out, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_run("after_rst", 2, {64'd0, 64'd0, 64'd1, 64'd1}, 2, 72'd2);

    // done already high when reset releases is not an edge
    rst = 1'b1; product = 64'd99; done = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("hi_done_drop", {71'd0, drop}, 72'd0);
    start = 1'b1; len = 9'd1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("hi_done_busy", {71'd0, busy}, 72'd1);
    check("hi_done_acc", acc_out, 72'd0);
    done = 1'b0;
    tick();
    pulse(64'd7);
    wait_valid("hi_done", 8);
    check("hi_done_final", acc_out, 72'd7);
    handshake("hi_done", 72'd7);
    $display("run hi_done len=1 acc_out=0x%0h", acc_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter N, default 32, multiplier operand width.
REQ-002 Parameter PW, default 2*N, signed product width.
REQ-003 Parameter GUARD, default 8, accumulator guard bits; ACC_W = PW+GUARD.
REQ-004 Parameter MAX_LEN, default 256, max terms per run; LW = $clog2(MAX_LEN)+1.
REQ-005 Port clk  in  1  single clock; all state on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port start  in  1  request new accumulation run.
REQ-008 Port len  in  LW  number of terms in run, sampled with start.
REQ-009 Port product  in  PW signed  multiplier result.
REQ-010 Port done  in  1  multiplier completion level; stays high until multiplier restarts.
REQ-011 Port busy  out  1  high in ACCUM.
REQ-012 Port acc_out  out  ACC_W signed  accumulated sum.
REQ-013 Port out_valid  out  1  acc_out holds a finished run.
REQ-014 Port out_ready  in  1  consumer accepts acc_out.
REQ-015 Port drop  out  1  sticky: a product arrived outside ACCUM.

Function
REQ-016 FSM states IDLE, ACCUM, HOLD; reset state IDLE.
REQ-017 Product accepted only on rising edge of done (done=1 and registered done_q=0); a level held high counts once.
REQ-018 IDLE: start=1 with len>0 -> clear acc to 0, remaining=len, enter ACCUM next cycle.
REQ-019 IDLE: start=1 with len=0 -> acc=0, enter HOLD directly.
REQ-020 ACCUM: on accepted edge, acc <= acc + sign-extended product (PW to ACC_W), remaining decrements.
REQ-021 ACCUM: accepted edge with remaining=1 -> final add performed, enter HOLD next cycle.
REQ-022 Accumulation latency: acc_out reflects a product 1 cycle after the done edge.
REQ-023 HOLD: out_valid=1, acc_out stable until out_ready=1; on that cycle return to IDLE, out_valid deasserts next cycle.
REQ-024 start ignored in ACCUM and HOLD, including the HOLD cycle where out_ready=1.
REQ-025 Done edge in IDLE or HOLD is discarded (acc unchanged) and sets drop; drop cleared only by an accepted start or reset.
REQ-026 len > MAX_LEN is clamped to MAX_LEN.
REQ-027 No overflow possible: ACC_W covers MAX_LEN products of magnitude up to 2^(PW-2); no saturation logic.
REQ-028 busy=1 exactly while in ACCUM; out_valid=1 exactly while in HOLD.
REQ-029 acc_out retains last value in IDLE until next accepted start.

Reset
REQ-030 rst=1 asynchronously forces: state IDLE, acc=0, remaining=0, done_q=0, busy=0, out_valid=0, drop=0.
REQ-031 rst mid-ACCUM or mid-HOLD abandons the run; no partial result is presented.
REQ-032 After rst deasserts, a done already high does not count as an edge (done_q reloads from done on first clock).

Structure
REQ-033 Package prod_accum_pkg holds the state enum (IDLE, ACCUM, HOLD) and default N, MAX_LEN constants.
REQ-034 One sub-module rise_det (clk, rst, d, rise) provides the done edge detector.

Verification
REQ-035 len=3, products 5, -7, 100 via three done pulses -> out_valid, acc_out=98, drop=0.
REQ-036 len=1, done held high 20 cycles with product=0x3FFFFFFF00000001 -> exactly one add, acc_out=0x003FFFFFFF00000001.
REQ-037 len=0, start -> HOLD next cycle, acc_out=0, out_valid=1; out_ready low 5 cycles keeps acc_out=0 and out_valid=1.
REQ-038 len=256, each product=-(2^62) -> acc_out=-(2^70), no wrap.
REQ-039 Done edge in IDLE with product=42 -> acc_out unchanged, drop=1; next start clears drop.
REQ-040 rst pulsed after 2 of 4 terms -> busy=0, out_valid=0, acc_out=0; new run len=2 of 1,1 -> acc_out=2.
